// File: rtl/tlv493_pkg.sv
// Shared types, register map and frame decoder for the TLV493D array poller.
package tlv493_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StRecv,
    StDecode,
    StNext,
    StWaitPeriod
  } poll_state_t;

  localparam logic [7:0] REG_BX      = 8'd0;
  localparam logic [7:0] REG_BY      = 8'd1;
  localparam logic [7:0] REG_BZ      = 8'd2;
  localparam logic [7:0] REG_TEMP    = 8'd3;
  localparam logic [7:0] REG_STATUS  = 8'd4;
  localparam logic [7:0] REG_ADDR    = 8'd5;
  localparam logic [7:0] GLOBAL_BANK = 8'hFF;
  localparam logic [7:0] REG_CTRL    = 8'd0;
  localparam logic [7:0] REG_PERIOD  = 8'd1;
  localparam logic [7:0] REG_ROUNDS  = 8'd2;

  // Index 0 is the first byte received (b0).
  typedef logic [0:6][7:0] tlv_frame_t;

  typedef struct packed {
    logic [11:0] bx;
    logic [11:0] by;
    logic [11:0] bz;
    logic [11:0] temp;
    logic [1:0]  frm;
    logic [1:0]  ch;
    logic        t;
    logic        ff;
    logic        pd;
  } tlv_sample_t;

  function automatic tlv_sample_t decode_frame(input tlv_frame_t b);
    tlv_sample_t s;
    s.bx   = {b[0], b[4][7:4]};
    s.by   = {b[1], b[4][3:0]};
    s.bz   = {b[2], b[5][3:0]};
    s.temp = {b[3][7:4], b[6]};
    s.frm  = b[3][3:2];
    s.ch   = b[3][1:0];
    s.t    = b[5][6];
    s.ff   = b[5][5];
    s.pd   = b[5][4];
    return s;
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tlv493_byte_assembler.sv
// Collects the 7 bytes of one sensor read into a frame; cleared by start.
module tlv493_byte_assembler (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [55:0] frame,
  output logic        frame_done
);

  logic [55:0] frame_q;
  logic [2:0]  count_q;
  logic        done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        frame_q <= '0;
        count_q <= '0;
      end else if (rx_valid && count_q != 3'd7) begin
        // First byte ends up in the top byte once all seven have arrived.
        frame_q <= {frame_q[47:0], rx_data};
        count_q <= count_q + 3'd1;
        done_q  <= (count_q == 3'd6);
      end
    end
  end

  assign frame      = frame_q;
  assign frame_done = done_q;

endmodule

// File: rtl/tlv493_array_poller.sv
// Round-robin poller for NUM_SENSORS TLV493D sensors behind one i2c_master, with an Avalon-MM
// register bank per sensor. Define TLV_FRAME_CHECK_EN to enable frame-counter continuity checks.
module tlv493_array_poller
  import tlv493_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_HZ = 50_000_000,
  parameter int unsigned NUM_SENSORS    = 4,
  parameter int unsigned RX_TIMEOUT     = 20_000,
  parameter logic [6:0]  ADDR_BASE      = 7'h5e
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic        i2c_ena,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_nbytes,
  input  logic        i2c_rx_valid,
  input  logic [7:0]  i2c_rx_data,
  input  logic        i2c_ack_error,
  input  logic        i2c_busy,
  output logic        round_done
);

  localparam int unsigned    IdxW        = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam logic [31:0]    PeriodReset = 32'(CLOCK_SPEED_HZ / 100);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_SENSORS - 1);

  poll_state_t     state_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     tmo_timer_q;
  logic [31:0]     period_cnt_q;

  tlv_sample_t     sample_q  [NUM_SENSORS];
  logic            valid_q   [NUM_SENSORS];
  logic [7:0]      frm_err_q [NUM_SENSORS];
  logic [7:0]      nack_q    [NUM_SENSORS];
  logic [1:0]      tmo_q     [NUM_SENSORS];
  logic [6:0]      addr_q    [NUM_SENSORS];
`ifdef TLV_FRAME_CHECK_EN
  logic            seen_q    [NUM_SENSORS];
  logic [1:0]      prev_frm_q[NUM_SENSORS];
  logic [1:0]      bad_run_q [NUM_SENSORS];
`endif

  logic            enable_q;
  logic [31:0]     period_q;
  logic [31:0]     round_cnt_q;
  logic            rd_ack_q;

  // Byte assembly
  logic [55:0] frame_bits;
  logic        frame_done;
  tlv_frame_t  frame;
  tlv_sample_t new_sample;

  tlv493_byte_assembler u_assembler (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (state_q == StIssue),
    .rx_valid   (i2c_rx_valid && (state_q == StRecv)),
    .rx_data    (i2c_rx_data),
    .frame      (frame_bits),
    .frame_done (frame_done)
  );

  assign frame      = frame_bits;
  assign new_sample = decode_frame(frame);

  // Poll events
  logic in_recv, ev_decode, ev_nack, ev_tmo, ev_round;
  assign in_recv   = (state_q == StRecv);
  assign ev_decode = (state_q == StDecode);
  assign ev_nack   = in_recv && !frame_done && i2c_ack_error;
  assign ev_tmo    = in_recv && !frame_done && !i2c_ack_error && (tmo_timer_q >= RX_TIMEOUT);
  assign ev_round  = (state_q == StNext) && (idx_q == LastIdx);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      tmo_timer_q  <= '0;
      period_cnt_q <= '0;
      i2c_ena      <= 1'b0;
      i2c_addr     <= ADDR_BASE;
      round_done   <= 1'b0;
    end else begin
      round_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (enable_q && !i2c_busy) state_q <= StIssue;
        end
        StIssue: begin
          i2c_addr    <= addr_q[idx_q];
          i2c_ena     <= 1'b1;
          tmo_timer_q <= '0;
          state_q     <= StRecv;
        end
        StRecv: begin
          // Timeout measures the gap since transaction start or the last byte.
          tmo_timer_q <= i2c_rx_valid ? '0 : tmo_timer_q + 32'd1;
          if (frame_done) begin
            i2c_ena <= 1'b0;
            state_q <= StDecode;
          end else if (ev_nack || ev_tmo) begin
            i2c_ena <= 1'b0;
            state_q <= StNext;
          end
        end
        StDecode: state_q <= StNext;
        StNext: begin
          if (idx_q == LastIdx) begin
            idx_q        <= '0;
            round_done   <= 1'b1;
            period_cnt_q <= period_q;
            state_q      <= StWaitPeriod;
          end else begin
            idx_q   <= idx_q + IdxW'(1);
            state_q <= enable_q ? StIssue : StIdle;
          end
        end
        StWaitPeriod: begin
          if (period_cnt_q == '0) state_q <= StIdle;
          else period_cnt_q <= period_cnt_q - 32'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign i2c_nbytes = 8'd7;

  // Avalon decode
  logic [7:0]      bank, regno;
  logic            bank_is_sensor;
  logic [IdxW-1:0] bank_idx;
  tlv_sample_t     rd_sample;
  logic [31:0]     rd_word;

  assign bank           = address[15:8];
  assign regno          = address[7:0];
  assign bank_is_sensor = (bank < 8'(NUM_SENSORS));
  assign bank_idx       = bank[IdxW-1:0];
  assign rd_sample      = sample_q[bank_idx];
  assign waitrequest    = read && !rd_ack_q;

  always_comb begin
    rd_word = '0;
    if (bank_is_sensor) begin
      case (regno)
        REG_BX:     rd_word = sext12(rd_sample.bx);
        REG_BY:     rd_word = sext12(rd_sample.by);
        REG_BZ:     rd_word = sext12(rd_sample.bz);
        REG_TEMP:   rd_word = {20'b0, rd_sample.temp};
        // T/FF/PD sit in [26:24]; [30:27] and [5:4] read as zero.
        REG_STATUS: rd_word = {valid_q[bank_idx], 4'b0, rd_sample.t, rd_sample.ff, rd_sample.pd,
                               frm_err_q[bank_idx], nack_q[bank_idx], tmo_q[bank_idx], 2'b0,
                               rd_sample.frm, rd_sample.ch};
        REG_ADDR:   rd_word = {25'b0, addr_q[bank_idx]};
        default:    rd_word = '0;
      endcase
    end else if (bank == GLOBAL_BANK) begin
      case (regno)
        REG_CTRL:   rd_word = {31'b0, enable_q};
        REG_PERIOD: rd_word = period_q;
        REG_ROUNDS: rd_word = round_cnt_q;
        default:    rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata    <= '0;
      rd_ack_q    <= 1'b0;
      enable_q    <= 1'b1;
      period_q    <= PeriodReset;
      round_cnt_q <= '0;
      for (int k = 0; k < NUM_SENSORS; k++) begin
        sample_q[k]  <= '0;
        valid_q[k]   <= 1'b0;
        frm_err_q[k] <= '0;
        nack_q[k]    <= '0;
        tmo_q[k]     <= '0;
        addr_q[k]    <= ADDR_BASE - 7'(k);
`ifdef TLV_FRAME_CHECK_EN
        seen_q[k]     <= 1'b0;
        prev_frm_q[k] <= '0;
        bad_run_q[k]  <= '0;
`endif
      end
    end else begin
      // Capture happens on the same edge as a DECODE write, so it sees the old snapshot.
      rd_ack_q <= read && !rd_ack_q;
      if (read && !rd_ack_q) readdata <= rd_word;

      if (ev_decode) begin
        sample_q[idx_q] <= new_sample;
`ifdef TLV_FRAME_CHECK_EN
        if (seen_q[idx_q] && (new_sample.frm != prev_frm_q[idx_q] + 2'd1)) begin
          frm_err_q[idx_q] <= sat_inc8(frm_err_q[idx_q]);
          bad_run_q[idx_q] <= (bad_run_q[idx_q] == 2'd3) ? 2'd3 : bad_run_q[idx_q] + 2'd1;
          valid_q[idx_q]   <= (bad_run_q[idx_q] < 2'd2);
        end else begin
          bad_run_q[idx_q] <= '0;
          valid_q[idx_q]   <= 1'b1;
        end
        seen_q[idx_q]     <= 1'b1;
        prev_frm_q[idx_q] <= new_sample.frm;
`else
        valid_q[idx_q] <= 1'b1;
`endif
      end
      if (ev_nack) begin
        nack_q[idx_q]  <= sat_inc8(nack_q[idx_q]);
        valid_q[idx_q] <= 1'b0;
      end
      if (ev_tmo) begin
        tmo_q[idx_q]   <= (tmo_q[idx_q] == 2'd3) ? 2'd3 : tmo_q[idx_q] + 2'd1;
        valid_q[idx_q] <= 1'b0;
      end
      if (ev_round) round_cnt_q <= round_cnt_q + 32'd1;

      if (write && bank_is_sensor && regno == REG_ADDR) addr_q[bank_idx] <= writedata[6:0];
      if (write && bank == GLOBAL_BANK) begin
        case (regno)
          REG_CTRL: begin
            enable_q <= writedata[0];
            if (writedata[1]) begin
              round_cnt_q <= '0;
              for (int k = 0; k < NUM_SENSORS; k++) begin
                frm_err_q[k] <= '0;
                nack_q[k]    <= '0;
                tmo_q[k]     <= '0;
              end
            end
          end
          REG_PERIOD: period_q <= writedata;
          default: ;
        endcase
      end
    end
  end

endmodule
